// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice.
// Holds the address/instruction types, fetch FSM state encoding, and the buffer entry layout.
// No logic, so no latency or backpressure behaviour.
package fetch_pkg;

   typedef logic [7:0]  addr_t;
   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Sequential fetch address; 8-bit arithmetic wraps FF -> 00 by construction.
   function automatic addr_t pc_next(input addr_t pc);
      return pc + 8'd1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: DEPTH entries of {pc, instr}, head exposed combinationally.
// Latency: a push is visible at the head one cycle later; pop frees the head at the clock edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush wins over both.
// Ports: clk, reset_n, push/pop/flush controls, wr_data in, rd_data (head) out, full/empty status.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               full,
   output logic               empty
);

   // Depth is limited to 2..4, so 2 pointer bits and 3 count bits always suffice.
   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = 3;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULLV = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == FULLV);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~flush;
   // When full, the slot being written is the one being popped this cycle.
   assign do_push = push & ~flush & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC + BOOT/RUN/HALT FSM feeding a small fetch buffer.
// Latency: instruction read at imem_addr in cycle N reaches the buffer head in cycle N+1.
// Backpressure: fetch stalls while the buffer is full and the head is not consumed; HALT drains only.
// Ports: clk, reset_n; imem_addr/imem_rdata memory side; instr_out/instr_pc/instr_valid/instr_ready
// consumer side; redirect/redirect_pc flush+refetch; halt_req stop fetching.
// Optional macro FETCH_PERF_EN adds fetch_count and stall_count (saturating) outputs.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int         BUF_DEPTH = 2,
   parameter logic [7:0] RESET_PC  = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [7:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [7:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   input  logic        halt_req
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] stall_count
`endif
);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   addr_t              pc;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head_raw;
   entry_t             head;
   entry_t             push_entry;

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= BOOT;
      else          state <= state_nxt;
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (!redirect && halt_req) state_nxt = HALT;
         HALT:    if (redirect) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   // ---------------- FSM outputs ----------------
   // Redirect freezes the buffer for its cycle: the flush discards everything anyway.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      if (!redirect) begin
         pop  = ~fifo_empty & instr_ready;
         push = (state == RUN) & ~halt_req & (~fifo_full | pop);
      end
   end

   // ---------------- PC ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      pc <= RESET_PC;
      else if (redirect) pc <= redirect_pc;
      else if (push)     pc <= pc_next(pc);
   end

   assign imem_addr = pc;

   // ---------------- Fetch buffer ----------------
   assign push_entry = '{pc: pc, instr: imem_rdata};

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect),
      .wr_data (push_entry),
      .rd_data (head_raw),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head        = head_raw;
   assign instr_valid = ~fifo_empty;
   // Stale storage must not leak to the consumer when nothing is buffered.
   assign instr_out   = fifo_empty ? '0 : head.instr;
   assign instr_pc    = fifo_empty ? '0 : head.pc;

`ifdef FETCH_PERF_EN
   // ---------------- Performance counters ----------------
   logic stall;
   assign stall = (state == RUN) & fifo_full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (push  && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
         if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: reset, first fetch, backpressure, redirect, PC wrap,
// halt/drain/resume, asynchronous mid-run reset and (with FETCH_PERF_EN) the perf counters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_fetch_ctrl;

   logic        clk;
   logic        reset_n;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halt_req;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count;
   logic [15:0] stall_count;
`endif

   int checks   = 0;
   int failures = 0;

   // Memory contents: address 0 holds 32'h20010003, other words derived from the address.
   function automatic logic [31:0] word(input logic [7:0] a);
      return {a ^ 8'h20, 24'h010003};
   endfunction

   assign imem_rdata = word(imem_addr);

   instr_fetch_ctrl #(
      .BUF_DEPTH (2),
      .RESET_PC  (8'h00)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_req    (halt_req)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Returns on the falling edge of the BOOT cycle.
   task automatic apply_reset(input logic rdy);
      @(negedge clk);
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      halt_req    = 1'b0;
      instr_ready = rdy;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      if (imem_addr !== 8'h00) begin failures++; $display("FAIL rst_addr: got %0h expected 0", imem_addr); end
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", instr_valid); end
      checks++;
      if (instr_out !== 32'h0) begin failures++; $display("FAIL rst_out: got %0h expected 0", instr_out); end
      checks++;
      if (instr_pc !== 8'h00) begin failures++; $display("FAIL rst_pc: got %0h expected 0", instr_pc); end
      checks++;
      apply_reset(1'b0);
      @(negedge clk); // cycle 1: BOOT must not have pushed
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL boot_valid: got %0b expected 0", instr_valid); end
      checks++;
      if (imem_addr !== 8'h00) begin failures++; $display("FAIL boot_addr: got %0h expected 0", imem_addr); end
      checks++;
   endtask

   task automatic test_first_fetch();
      apply_reset(1'b1);
      @(negedge clk); // cycle 1
      if (imem_addr !== 8'h00) begin failures++; $display("FAIL ff_addr0: got %0h expected 0", imem_addr); end
      checks++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (instr_valid !== 1'b1) begin failures++; $display("FAIL ff_valid%0d: got %0b expected 1", k, instr_valid); end
         checks++;
         if (instr_pc !== 8'(k)) begin failures++; $display("FAIL ff_pc%0d: got %0h expected %0h", k, instr_pc, k); end
         checks++;
         if (instr_out !== word(8'(k))) begin failures++; $display("FAIL ff_out%0d: got %0h expected %0h", k, instr_out, word(8'(k))); end
         checks++;
         if (imem_addr !== 8'(k + 1)) begin failures++; $display("FAIL ff_addr%0d: got %0h expected %0h", k, imem_addr, k + 1); end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      apply_reset(1'b0);
      repeat (3) @(negedge clk); // cycle 3: two entries buffered
      for (int k = 0; k < 3; k++) begin
         if (imem_addr !== 8'h02) begin failures++; $display("FAIL bp_addr%0d: got %0h expected 2", k, imem_addr); end
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            failures++; $display("FAIL bp_head%0d: got valid=%0b pc=%0h expected valid=1 pc=0", k, instr_valid, instr_pc);
         end
         checks++;
         @(negedge clk);
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (instr_pc !== 8'(k) || instr_out !== word(8'(k))) begin
            failures++; $display("FAIL bp_pop%0d: got pc=%0h out=%0h expected pc=%0h", k, instr_pc, instr_out, k);
         end
         checks++;
         @(negedge clk);
      end
      if (imem_addr !== 8'h05) begin failures++; $display("FAIL bp_addr_end: got %0h expected 5", imem_addr); end
      checks++;
   endtask

   task automatic test_redirect();
      apply_reset(1'b1);
      repeat (5) @(negedge clk); // cycle 5: head pc 3, fetching 4
      instr_ready = 1'b0;
      @(negedge clk); // cycle 6: entries 3,4
      if (instr_pc !== 8'h03 || imem_addr !== 8'h05) begin
         failures++; $display("FAIL rd_setup: got pc=%0h addr=%0h expected pc=3 addr=5", instr_pc, imem_addr);
      end
      checks++;
      redirect    = 1'b1;
      redirect_pc = 8'h08;
      instr_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL rd_flush: got valid=%0b expected 0", instr_valid); end
      checks++;
      if (imem_addr !== 8'h08) begin failures++; $display("FAIL rd_addr: got %0h expected 8", imem_addr); end
      checks++;
      if (instr_pc !== 8'h00 || instr_out !== 32'h0) begin
         failures++; $display("FAIL rd_empty_out: got pc=%0h out=%0h expected 0", instr_pc, instr_out);
      end
      checks++;
      @(negedge clk);
      if (instr_valid !== 1'b1 || instr_pc !== 8'h08 || instr_out !== word(8'h08)) begin
         failures++; $display("FAIL rd_head: got valid=%0b pc=%0h out=%0h expected pc=8", instr_valid, instr_pc, instr_out);
      end
      checks++;
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc;
      redirect    = 1'b1;
      redirect_pc = 8'hFE;
      instr_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      if (imem_addr !== 8'hFE || instr_valid !== 1'b0) begin
         failures++; $display("FAIL wr_addr: got addr=%0h valid=%0b expected FE/0", imem_addr, instr_valid);
      end
      checks++;
      exp_pc = 8'hFE;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== word(exp_pc)) begin
            failures++; $display("FAIL wr_head%0d: got pc=%0h out=%0h expected pc=%0h", k, instr_pc, instr_out, exp_pc);
         end
         checks++;
         exp_pc = exp_pc + 8'd1;
      end
   endtask

   task automatic test_halt();
      apply_reset(1'b0);
      repeat (3) @(negedge clk); // cycle 3: entries 0,1, PC=2
      halt_req    = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || imem_addr !== 8'h02) begin
         failures++; $display("FAIL ht_drain1: got valid=%0b pc=%0h addr=%0h expected 1/1/2", instr_valid, instr_pc, imem_addr);
      end
      checks++;
      @(negedge clk);
      if (instr_valid !== 1'b0 || instr_out !== 32'h0 || imem_addr !== 8'h02) begin
         failures++; $display("FAIL ht_drained: got valid=%0b out=%0h addr=%0h expected 0/0/2", instr_valid, instr_out, imem_addr);
      end
      checks++;
      @(negedge clk);
      if (instr_valid !== 1'b0 || imem_addr !== 8'h02) begin
         failures++; $display("FAIL ht_persist: got valid=%0b addr=%0h expected 0/2", instr_valid, imem_addr);
      end
      checks++;
      redirect    = 1'b1;
      redirect_pc = 8'h04;
      @(negedge clk);
      redirect = 1'b0;
      if (imem_addr !== 8'h04 || instr_valid !== 1'b0) begin
         failures++; $display("FAIL ht_redir: got addr=%0h valid=%0b expected 4/0", imem_addr, instr_valid);
      end
      checks++;
      @(negedge clk);
      if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || imem_addr !== 8'h05) begin
         failures++; $display("FAIL ht_resume: got valid=%0b pc=%0h addr=%0h expected 1/4/5", instr_valid, instr_pc, imem_addr);
      end
      checks++;
      @(negedge clk);
      if (instr_pc !== 8'h05) begin failures++; $display("FAIL ht_resume2: got pc=%0h expected 5", instr_pc); end
      checks++;
   endtask

   task automatic test_async_reset();
      apply_reset(1'b1);
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      if (instr_valid !== 1'b0 || imem_addr !== 8'h00 || instr_pc !== 8'h00 || instr_out !== 32'h0) begin
         failures++; $display("FAIL ar_async: got valid=%0b addr=%0h pc=%0h out=%0h expected all 0",
                              instr_valid, imem_addr, instr_pc, instr_out);
      end
      checks++;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin
         failures++; $display("FAIL ar_boot: got valid=%0b addr=%0h expected 0/0", instr_valid, imem_addr);
      end
      checks++;
      @(negedge clk);
      if (instr_pc !== 8'h00 || instr_out !== 32'h20010003) begin
         failures++; $display("FAIL ar_refetch: got pc=%0h out=%0h expected 0/20010003", instr_pc, instr_out);
      end
      checks++;
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf_counters();
      apply_reset(1'b0);
      repeat (13) @(negedge clk);
      if (stall_count !== 16'd10) begin failures++; $display("FAIL pf_stall: got %0d expected 10", stall_count); end
      checks++;
      if (fetch_count !== 16'd2) begin failures++; $display("FAIL pf_fetch: got %0d expected 2", fetch_count); end
      checks++;
      #2 reset_n = 1'b0;
      #1;
      if (stall_count !== 16'd0 || fetch_count !== 16'd0 || instr_valid !== 1'b0) begin
         failures++; $display("FAIL pf_reset: got stall=%0d fetch=%0d valid=%0b expected 0/0/0",
                              stall_count, fetch_count, instr_valid);
      end
      checks++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask
`endif

   initial begin
      reset_n     = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      halt_req    = 1'b0;
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_async_reset();
`ifdef FETCH_PERF_EN
      test_perf_counters();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, meaning fetch buffer entries (legal 2..4).
REQ-002 SHALL have parameter RESET_PC, default 8'h00, meaning first fetch address after reset.
REQ-003 SHALL have ports, one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_addr  out  8  instruction memory address; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word from memory
- instr_out  out  32  buffered instruction at buffer head
- instr_pc  out  8  address of instr_out
- instr_valid  out  1  buffer head holds an instruction
- instr_ready  in  1  consumer accepts head this cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  8  new fetch address
- halt_req  in  1  stop fetching

Function
REQ-004 SHALL hold an 8-bit PC; imem_addr SHALL equal PC combinationally.
REQ-005 SHALL have FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-006 SHALL push {PC, imem_rdata} and set PC<=PC+1 in a cycle only when state=RUN, redirect=0, halt_req=0, and (count<BUF_DEPTH or a pop occurs in the same cycle).
REQ-007 PC increment SHALL wrap 8'hFF -> 8'h00 without error.
REQ-008 A pop SHALL occur when instr_valid=1 and instr_ready=1; instr_valid SHALL be 1 iff count>0.
REQ-009 Simultaneous push and pop SHALL leave count unchanged, including when the buffer is full.
REQ-010 Redirect=1 SHALL, in that cycle, suppress push and pop, flush all entries (count<=0), set PC<=redirect_pc; it SHALL take priority over halt_req, pop, and push.
REQ-011 Redirect in HALT SHALL load PC and move to RUN; redirect in BOOT SHALL load PC and move to RUN.
REQ-012 halt_req=1 in RUN (without redirect) SHALL move to HALT; HALT SHALL stop pushing but continue popping so the buffer drains.
REQ-013 FSM state HALT SHALL persist until redirect=1.
REQ-014 instr_out and instr_pc SHALL be 0 when count=0.
REQ-015 Fetch-to-valid latency SHALL be one cycle: an instruction at address X on imem_addr in cycle N appears at the head no earlier than cycle N+1.

Reset
REQ-016 On reset_n=0, asynchronously: PC=RESET_PC, count=0, FSM=BOOT, instr_valid=0, instr_out=0, instr_pc=0, imem_addr=RESET_PC.
REQ-017 Reset asserted mid-operation SHALL discard all buffered instructions; no partial state SHALL survive.

Configuration
REQ-018 With macro FETCH_PERF_EN defined, the block SHALL add outputs fetch_count[15:0] (pushes) and stall_count[15:0] (RUN cycles with full buffer and no pop), both saturating at 16'hFFFF and reset to 0.
REQ-019 Without FETCH_PERF_EN, these ports and counters SHALL NOT exist.

Structure
REQ-020 Package fetch_pkg SHALL hold addr_t (8 bits), instr_t (32 bits), fetch_state_t enum {BOOT, RUN, HALT}, and the entry struct {addr_t pc; instr_t instr}.
REQ-021 Buffer storage, pointers, and count SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty); the FSM and PC logic SHALL stay in instr_fetch_ctrl.

Verification
REQ-022 Reset release, instr_ready=1, memory returning 32'h20010003 at 0 -> imem_addr 0 in cycle 1, instr_valid=1 with instr_pc=0, instr_out=32'h20010003 in cycle 2; PC then advances 1, 2, 3.
REQ-023 instr_ready=0 from reset -> exactly 2 pushes (PC stops at 8'h02), instr_valid stays 1, head instr_pc=0; then instr_ready=1 -> pops 0, 1, 2 in order, one per cycle.
REQ-024 Buffer holding pc 3 and 4, redirect=1 with redirect_pc=8'h08 and instr_ready=1 in the same cycle -> no pop, count=0 next cycle, imem_addr=8'h08, next head instr_pc=8'h08.
REQ-025 redirect_pc=8'hFE, instr_ready=1 -> head sequence FE, FF, 00, 01.
REQ-026 halt_req=1 with 2 entries buffered -> no further pushes, PC frozen, both entries drain, instr_valid=0; redirect to 8'h04 -> RUN, fetch resumes at 8'h04.
REQ-027 Under FETCH_PERF_EN, instr_ready=0 for 10 cycles after fill -> stall_count=10, fetch_count=2; reset_n pulsed low mid-run -> both 0, instr_valid=0 immediately.
